// File: rtl/commit_trace_buffer.sv
// Commit trace sink for the single-cycle cpu: classifies each sampled commit
// cycle into a numbered record, queues it in a FIFO and keeps run counters.
module commit_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic [15:0]      c_pc,
    input  logic             c_regwrite,
    input  logic [3:0]       c_write_reg,
    input  logic [15:0]      c_write_data,
    input  logic             c_memread,
    input  logic             c_memwrite,
    input  logic [15:0]      c_mem_addr,
    input  logic [15:0]      c_mem_wdata,
    input  logic             c_halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_kind,
    output logic [CNT_W-1:0] out_inum,
    output logic [15:0]      out_pc,
    output logic [3:0]       out_reg,
    output logic [15:0]      out_value,
    output logic [15:0]      out_addr,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic             overflow,
    output logic [15:0]      drop_count,
    output logic             halted,
    output logic             timeout,
    output logic             done
);

    localparam int               AW        = $clog2(DEPTH);
    localparam logic [AW:0]      RSV_LIMIT = (AW+1)'(DEPTH - 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);

    localparam logic [2:0] K_REG   = 3'd0;
    localparam logic [2:0] K_LOAD  = 3'd1;
    localparam logic [2:0] K_STORE = 3'd2;
    localparam logic [2:0] K_OTHER = 3'd3;
    localparam logic [2:0] K_HALT  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_TIMEOUT} state_t;

    typedef struct packed {
        logic [2:0]       kind;
        logic [CNT_W-1:0] inum;
        logic [15:0]      pc;
        logic [3:0]       rd;
        logic [15:0]      value;
        logic [15:0]      addr;
    } rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [15:0]      drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    rec_t             mem_q [DEPTH];
    rec_t             rec_d;
    rec_t             head;
    logic             sample, pop, push;
    logic [AW:0]      occ_after_pop;

    // Classification: LOAD beats REG beats HALT beats STORE; unused fields stay 0.
    always_comb begin
        rec_d      = '0;
        rec_d.inum = inst_count_q;
        rec_d.pc   = c_pc;
        if (c_regwrite && c_memread) begin
            rec_d.kind  = K_LOAD;
            rec_d.rd    = c_write_reg;
            rec_d.value = c_write_data;
            rec_d.addr  = c_mem_addr;
        end else if (c_regwrite) begin
            rec_d.kind  = K_REG;
            rec_d.rd    = c_write_reg;
            rec_d.value = c_write_data;
        end else if (c_halt) begin
            rec_d.kind  = K_HALT;
        end else if (c_memwrite) begin
            rec_d.kind  = K_STORE;
            rec_d.value = c_mem_wdata;
            rec_d.addr  = c_mem_addr;
        end else begin
            rec_d.kind  = K_OTHER;
        end
    end

    always_comb begin
        state_d       = state_q;
        inst_count_d  = inst_count_q;
        cycle_count_d = cycle_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;

        sample        = cap_en && (state_q == S_IDLE || state_q == S_RUN);
        pop           = (count_q != '0) && out_ready;
        occ_after_pop = count_q - (AW+1)'(pop);
        // One slot is held back so a HALT record always finds room.
        push          = sample && ((rec_d.kind == K_HALT) || (occ_after_pop < RSV_LIMIT));

        if (sample) begin
            inst_count_d  = inst_count_q + 1'b1;
            cycle_count_d = cycle_count_q + 1'b1;
            if (!push) begin
                overflow_d   = 1'b1;
                drop_count_d = sat_inc16(drop_count_q);
            end
            if (rec_d.kind == K_HALT) begin
                state_d = S_HALTED;
            end else if (cycle_count_d == MAX_CNT) begin
                state_d = S_TIMEOUT;
            end else begin
                state_d = S_RUN;
            end
        end

        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            inst_count_q  <= '0;
            cycle_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            inst_count_q  <= inst_count_d;
            cycle_count_q <= cycle_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage is not reset; the empty-FIFO gating below hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rec_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_valid   = (count_q != '0);
    assign out_kind    = out_valid ? head.kind  : '0;
    assign out_inum    = out_valid ? head.inum  : '0;
    assign out_pc      = out_valid ? head.pc    : '0;
    assign out_reg     = out_valid ? head.rd    : '0;
    assign out_value   = out_valid ? head.value : '0;
    assign out_addr    = out_valid ? head.addr  : '0;

    assign inst_count  = inst_count_q;
    assign cycle_count = cycle_count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
    assign halted      = (state_q == S_HALTED);
    assign timeout     = (state_q == S_TIMEOUT);
    assign done        = (halted || timeout) && (count_q == '0);

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Hardware trace sink directly downstream of the single-cycle cpu. It samples the cpu's per-cycle commit signals and classifies each cycle as register write, load, store, halt, or other (branch/NOP). Each cycle becomes one numbered trace record, buffered in a FIFO and drained over a valid/ready port. It also keeps cycle and instruction counters and a cycle-timeout watchdog, so regression runs can compare traces without simulator file I/O.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=4)
CNT_W, 32, width of inst/cycle counters and record INUM field
MAX_CYCLES, 100000, watchdog limit on captured cycles

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
cap_en  in  1  cpu out of reset; capture only when high
c_pc  in  16  pc of committing instruction
c_regwrite  in  1  register file written this cycle
c_write_reg  in  4  destination register
c_write_data  in  16  register write data
c_memread  in  1  data memory read this cycle
c_memwrite  in  1  data memory write this cycle
c_mem_addr  in  16  memory address (ALU result)
c_mem_wdata  in  16  store data
c_halt  in  1  halt committing
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head record
out_kind  out  3  0 REG, 1 LOAD, 2 STORE, 3 OTHER, 4 HALT
out_inum  out  CNT_W  instruction number of record
out_pc  out  16  record pc
out_reg  out  4  dest reg (REG/LOAD), else 0
out_value  out  16  write data (REG/LOAD) or store data (STORE), else 0
out_addr  out  16  mem address (LOAD/STORE), else 0
inst_count  out  CNT_W  records generated (incl. dropped)
cycle_count  out  CNT_W  cycles sampled in RUN
overflow  out  1  sticky: at least one record dropped
drop_count  out  16  dropped records, saturating at 0xFFFF
halted  out  1  halt record captured
timeout  out  1  watchdog expired
done  out  1  (halted|timeout) and FIFO empty

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; FIFO empty; all counters 0; overflow/halted/timeout/done 0; out_valid 0; out_* fields 0.
- States: IDLE -> RUN when cap_en=1 (sampling starts in that same cycle). RUN -> HALTED on a captured halt. RUN -> TIMEOUT when cycle_count reaches MAX_CYCLES. HALTED and TIMEOUT are terminal until reset. cap_en=0 in RUN pauses sampling and counting.
- Classification priority, one record per sampled cycle: c_regwrite&c_memread -> LOAD; else c_regwrite -> REG; else c_halt -> HALT; else c_memwrite -> STORE; else OTHER. Unused fields are forced to 0.
- out_inum = inst_count before increment; first record has inum 0. inst_count increments by 1 every sampled cycle, including dropped records. cycle_count increments every sampled RUN cycle.
- FIFO: registered storage; a record is visible on out_valid on the cycle after capture (1-cycle latency). Pop when out_valid&out_ready. Outputs hold stable while out_valid=1 and out_ready=0.
- Halt reservation: non-HALT records are accepted only while occupancy (after any same-cycle pop) < DEPTH-1. A HALT record is always accepted, so it is never lost. A refused record sets overflow and increments drop_count.
- Simultaneous push and pop: pop is applied first; occupancy is unchanged and data order is preserved. Pointers wrap modulo DEPTH.
- HALTED/TIMEOUT: no further capture; counters frozen; draining continues; done rises the cycle the FIFO becomes empty.
- Mid-operation reset: all contents discarded, state IDLE, no stale out_valid on the cycle after reset.

Test Plan:
- Reset, then cap_en=1 with three cycles REG(pc 0,r1,0x0005), STORE(pc 2,addr 0x0010,data 0x0005), HALT(pc 4), out_ready=1 -> records kind 0/2/4, inum 0/1/2, halted=1, done=1 one cycle after last pop, inst_count=3.
- Cycle with c_regwrite=1, c_memread=1, reg 3, data 0xBEEF, addr 0x0020 -> LOAD record with out_addr=0x0020, out_value=0xBEEF.
- DEPTH=16, out_ready=0, 20 OTHER cycles then HALT -> 15 OTHER records kept, 5 dropped (drop_count=5, overflow=1), HALT stored as 16th entry with inum 20.
- Full FIFO minus reservation, out_ready=1 every cycle with continuous REG input -> no drops, inum strictly sequential on output.
- MAX_CYCLES=8, no halt -> timeout=1 after 8 sampled cycles, cycle_count=8, later inputs ignored, done after drain.
- Assert rst_n=0 for one cycle while FIFO holds 5 records -> out_valid=0, counters 0, state IDLE next cycle.
